i2c_poll_sequencer: RTL and testbench
=====================================

Name: i2c_poll_sequencer

Overview:
- Command sequencer directly upstream of the I2C master. Drives the master's start/addr/data/two_bytes/rw inputs and consumes its ready/read_data outputs.
- After reset it writes one 16-bit configuration word to the slave. It then polls a 16-bit result register forever: a 1-byte pointer write, a 2-byte read, then an idle interval.
- Each read result is published with a one-cycle valid strobe.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit slave address used on every transaction
- CFG_WORD, 16'h0160, word sent by the init write (MSB byte first)
- RESULT_PTR, 8'h00, pointer byte written before every read
- POLL_CYCLES, 1000, idle clk cycles between the end of one read and the next pointer write (>=1)
- ACK_TIMEOUT, 8, max cycles to wait for i2c_ready to fall after start

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  1 = run sequence; 0 = park after the current transaction
- i2c_start  out  1  start pulse to the master
- i2c_addr  out  7  slave address to the master
- i2c_data  out  16  write data to the master (16'd0 for reads)
- i2c_two_bytes  out  1  1 = 2 data bytes
- i2c_rw  out  1  0 = write, 1 = read
- i2c_read_data  in  16  read result from the master
- i2c_ready  in  1  master idle
- sample  out  16  last read result
- sample_valid  out  1  1-cycle strobe when sample updates
- init_done  out  1  config write has completed
- error  out  1  1-cycle strobe on ACK_TIMEOUT expiry
- busy  out  1  high in any state except S_PARK

Behaviour:
- Reset values: state S_PARK; i2c_start=0, i2c_addr=SLAVE_ADDR, i2c_data=0, i2c_two_bytes=0, i2c_rw=0; sample=0, sample_valid=0, init_done=0, error=0; interval and timeout counters = 0. Reset in mid-operation aborts immediately; init is re-run afterwards.
- Transaction steps (step register): INIT = write, two_bytes=1, data=CFG_WORD. PTR = write, two_bytes=0, data={8'h00,RESULT_PTR}. READ = read, two_bytes=1, data=0.
- Every step runs through three states:
  - S_ISSUE: wait for i2c_ready=1, then assert i2c_start for exactly one cycle and go to S_ACK.
  - S_ACK: wait for i2c_ready=0, then go to S_DONE. The timeout counter increments each cycle; when it reaches ACK_TIMEOUT, pulse error and go to S_WAIT with a full interval.
  - S_DONE: wait for i2c_ready=1, then advance the step.
- i2c_addr/data/two_bytes/rw are registered. They are valid no later than the cycle i2c_start is high and stay stable until S_DONE exits.
- Step advance:
  - INIT done: set init_done=1 (sticky until rst), go to PTR issue.
  - PTR done: go to READ issue.
  - READ done: the same cycle S_DONE exits, capture sample <= i2c_read_data and pulse sample_valid=1 for that one cycle. Go to S_WAIT.
- S_WAIT: load the counter with POLL_CYCLES-1 and count down to 0. Then, if enable=1, go to PTR issue; otherwise go to S_PARK.
- S_PARK: entered from reset or from S_WAIT. On enable=1, go to INIT issue if init_done=0, else PTR issue.
- enable falling mid-transaction has no effect until S_WAIT ends. The in-flight steps complete, including the read.
- Slave NACK is invisible at this interface: the master returns to ready with undefined read_data. The sequencer still publishes; filtering is a downstream job.
- Simultaneous cases:
  - i2c_ready=0 in S_ISSUE: hold; start is not asserted.
  - i2c_ready=1 on the first S_ACK cycle: counts as not yet acknowledged.

Test Plan:
- Reset then enable=1, with a master model whose ready falls 1 cycle after start and rises 30 cycles later -> 1st start with rw=0, two_bytes=1, data=16'h0160, addr=7'h48; init_done=1 after ready returns; 2nd start with data=16'h0000, two_bytes=0.
- Model returns read_data=16'h1A2B on the READ step -> sample=16'h1A2B, sample_valid high exactly 1 cycle. Next PTR start occurs POLL_CYCLES(=1000, use 20 in bench) cycles after the strobe.
- Model ready stuck at 1 after start -> error pulses after 8 cycles; no sample_valid; retry PTR after the interval.
- enable dropped during the READ step -> read completes and is published; sequencer parks with busy=0; re-enable -> PTR issued next, no init rewrite.
- rst asserted in the middle of READ S_DONE -> all outputs at reset values the next cycle; on enable, the init write is issued again.
- i2c_ready low at S_ISSUE entry for 5 cycles -> i2c_start stays 0 until ready=1, then pulses once.

Source files
------------

// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer
// Drives an I2C master: one configuration write after reset, then an endless
// loop of pointer write, 2-byte result read and idle interval. Each read result
// is published on sample with a one-cycle sample_valid strobe.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            1 = run; 0 = park once the current interval ends
//   i2c_start         one-cycle start request to the master
//   i2c_addr/data     registered transaction fields (data = 0 for reads)
//   i2c_two_bytes     1 = two data bytes
//   i2c_rw            0 = write, 1 = read
//   i2c_read_data     read result from the master
//   i2c_ready         master idle
//   sample            last read result
//   sample_valid      strobe, high the cycle sample updates
//   init_done         sticky: configuration write has completed
//   error             strobe: master never acknowledged a start in time
//   busy              high in every state except S_PARK
module i2c_poll_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter logic [15:0] CFG_WORD    = 16'h0160,
  parameter logic [7:0]  RESULT_PTR  = 8'h00,
  parameter int          POLL_CYCLES = 1000,
  parameter int          ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic [15:0] i2c_data,
  output logic        i2c_two_bytes,
  output logic        i2c_rw,
  input  logic [15:0] i2c_read_data,
  input  logic        i2c_ready,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        init_done,
  output logic        error,
  output logic        busy
);

  // state   | meaning
  // S_PARK  | idle; waits for enable
  // S_ISSUE | waits for master ready, then fires i2c_start
  // S_ACK   | waits for master to go busy (ready low), with timeout
  // S_DONE  | waits for master ready again, then advances the step
  // S_WAIT  | idle interval down-counter before the next poll

  localparam int WAIT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(POLL_CYCLES - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_PARK, S_ISSUE, S_ACK, S_DONE, S_WAIT} state_t;
  typedef enum logic [1:0] {ST_INIT, ST_PTR, ST_READ} step_t;

  state_t state, state_d;
  step_t  step, step_d;

  logic [WAIT_W-1:0] wait_cnt;
  logic [ACK_W-1:0]  ack_cnt;

  logic load_cmd, load_wait, wait_dec, ack_clr, ack_inc, capture, set_init;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_PARK;
      step          <= ST_INIT;
      wait_cnt      <= '0;
      ack_cnt       <= '0;
      i2c_addr      <= SLAVE_ADDR;
      i2c_data      <= '0;
      i2c_two_bytes <= 1'b0;
      i2c_rw        <= 1'b0;
      sample        <= '0;
      sample_valid  <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      state        <= state_d;
      step         <= step_d;
      sample_valid <= capture;
      if (capture)  sample    <= i2c_read_data;
      if (set_init) init_done <= 1'b1;

      if (load_wait)     wait_cnt <= WAIT_LOAD;
      else if (wait_dec) wait_cnt <= wait_cnt - WAIT_W'(1);

      if (ack_clr)      ack_cnt <= '0;
      else if (ack_inc) ack_cnt <= ack_cnt + ACK_W'(1);

      // Command fields are loaded on entry to S_ISSUE so they are settled
      // before start fires and held until the step advances.
      if (load_cmd) begin
        i2c_addr <= SLAVE_ADDR;
        case (step_d)
          ST_INIT: begin
            i2c_data      <= CFG_WORD;
            i2c_two_bytes <= 1'b1;
            i2c_rw        <= 1'b0;
          end
          ST_PTR: begin
            i2c_data      <= {8'h00, RESULT_PTR};
            i2c_two_bytes <= 1'b0;
            i2c_rw        <= 1'b0;
          end
          default: begin
            i2c_data      <= '0;
            i2c_two_bytes <= 1'b1;
            i2c_rw        <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d   = state;
    step_d    = step;
    i2c_start = 1'b0;
    error     = 1'b0;
    busy      = (state != S_PARK);
    load_cmd  = 1'b0;
    load_wait = 1'b0;
    wait_dec  = 1'b0;
    ack_clr   = 1'b0;
    ack_inc   = 1'b0;
    capture   = 1'b0;
    set_init  = 1'b0;

    case (state)
      S_PARK: begin
        if (enable) begin
          step_d   = init_done ? ST_PTR : ST_INIT;
          state_d  = S_ISSUE;
          load_cmd = 1'b1;
        end
      end

      S_ISSUE: begin
        if (i2c_ready) begin
          i2c_start = 1'b1;
          ack_clr   = 1'b1;
          state_d   = S_ACK;
        end
      end

      // Ready still high here means the master has not taken the request yet,
      // even on the very first cycle after start.
      S_ACK: begin
        if (!i2c_ready) begin
          state_d = S_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          error     = 1'b1;
          load_wait = 1'b1;
          state_d   = S_WAIT;
        end else begin
          ack_inc = 1'b1;
        end
      end

      S_DONE: begin
        if (i2c_ready) begin
          case (step)
            ST_INIT: begin
              set_init = 1'b1;
              step_d   = ST_PTR;
              state_d  = S_ISSUE;
              load_cmd = 1'b1;
            end
            ST_PTR: begin
              step_d   = ST_READ;
              state_d  = S_ISSUE;
              load_cmd = 1'b1;
            end
            default: begin
              // Published even on a NACKed read; filtering happens downstream.
              capture   = 1'b1;
              load_wait = 1'b1;
              state_d   = S_WAIT;
            end
          endcase
        end
      end

      S_WAIT: begin
        if (wait_cnt == '0) begin
          if (enable) begin
            step_d   = ST_PTR;
            state_d  = S_ISSUE;
            load_cmd = 1'b1;
          end else begin
            state_d = S_PARK;
          end
        end else begin
          wait_dec = 1'b1;
        end
      end

      default: state_d = S_PARK;
    endcase
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// tb_i2c_poll_sequencer
// Directed scenario sequence with randomized read data and enable timing.
// A small I2C master model answers starts; the bench keeps a transaction-level
// reference (expected step kinds, returned read values, interval arithmetic).
module tb_i2c_poll_sequencer;

  localparam int P  = 20;
  localparam int TO = 8;
  localparam logic [6:0]  ADDR = 7'h48;
  localparam logic [15:0] CFG  = 16'h0160;
  localparam logic [7:0]  PTRB = 8'h00;
  localparam int K_INIT = 0, K_PTR = 1, K_READ = 2;
  localparam int BUSY_CYCLES = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        i2c_start;
  logic [6:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        i2c_two_bytes;
  logic        i2c_rw;
  logic [15:0] i2c_read_data = 16'h0;
  logic        i2c_ready = 1'b1;
  logic [15:0] sample;
  logic        sample_valid;
  logic        init_done;
  logic        error;
  logic        busy;

  i2c_poll_sequencer #(
    .SLAVE_ADDR (ADDR),
    .CFG_WORD   (CFG),
    .RESULT_PTR (PTRB),
    .POLL_CYCLES(P),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i2c_start    (i2c_start),
    .i2c_addr     (i2c_addr),
    .i2c_data     (i2c_data),
    .i2c_two_bytes(i2c_two_bytes),
    .i2c_rw       (i2c_rw),
    .i2c_read_data(i2c_read_data),
    .i2c_ready    (i2c_ready),
    .sample       (sample),
    .sample_valid (sample_valid),
    .init_done    (init_done),
    .error        (error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Event logs filled at the falling edge.
  int          cyc = 0;
  int          st_cyc[$];
  logic [6:0]  st_addr[$];
  logic [15:0] st_data[$];
  logic        st_two[$];
  logic        st_rw[$];
  logic        st_init[$];
  int          sv_cyc[$];
  logic [15:0] sv_val[$];
  int          er_cyc[$];
  int          start_double = 0;
  int          sv_double = 0;
  logic        prev_start = 1'b0;
  logic        prev_sv = 1'b0;

  // Master model controls.
  logic        stuck = 1'b0;
  int          hold_cnt = 0;
  logic [15:0] rd_next = 16'h0;
  int          busy_left = 0;
  logic        last_rw = 1'b0;
  logic        nr = 1'b1;
  logic [15:0] nrd = 16'h0;

  always @(negedge clk) begin
    cyc++;
    if (i2c_start) begin
      st_cyc.push_back(cyc);
      st_addr.push_back(i2c_addr);
      st_data.push_back(i2c_data);
      st_two.push_back(i2c_two_bytes);
      st_rw.push_back(i2c_rw);
      st_init.push_back(init_done);
      if (prev_start) start_double++;
    end
    prev_start = i2c_start;
    if (sample_valid) begin
      sv_cyc.push_back(cyc);
      sv_val.push_back(sample);
      if (prev_sv) sv_double++;
    end
    prev_sv = sample_valid;
    if (error) er_cyc.push_back(cyc);

    // Master: goes busy the cycle after a start, stays busy BUSY_CYCLES,
    // returns ready with read data for reads. Stuck mode ignores starts.
    if (i2c_start && !stuck && busy_left == 0) begin
      busy_left = BUSY_CYCLES;
      last_rw   = i2c_rw;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && last_rw) nrd = rd_next;
    end
    if (hold_cnt > 0) begin
      hold_cnt--;
      nr = 1'b0;
    end else begin
      nr = (busy_left == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    i2c_ready     = nr;
    i2c_read_data = nrd;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int which);
    if (which == 0) return st_cyc.size();
    if (which == 1) return sv_cyc.size();
    return er_cyc.size();
  endfunction

  task automatic wait_q(input int which, input int n, input int lim, input string tag);
    int c = 0;
    while (qsize(which) < n && c < lim) begin
      tick(1);
      c++;
    end
    chk({tag, "_arrived"}, 32'(qsize(which) >= n), 1);
  endtask

  int si = 0;  // starts consumed
  int ni = 0;  // strobes consumed

  task automatic next_start(input int kind, input string tag, input int lim);
    wait_q(0, si + 1, lim, tag);
    if (st_cyc.size() > si) begin
      chk({tag, "_addr"}, 32'(st_addr[si]), 32'(ADDR));
      chk({tag, "_rw"},   32'(st_rw[si]),   32'(kind == K_READ));
      chk({tag, "_two"},  32'(st_two[si]),  32'(kind != K_PTR));
      chk({tag, "_data"}, 32'(st_data[si]),
          (kind == K_INIT) ? 32'(CFG) : (kind == K_PTR) ? 32'(PTRB) : 32'h0);
      si++;
    end
  endtask

  task automatic next_strobe(input logic [15:0] exp, input string tag, input int lim);
    wait_q(1, ni + 1, lim, tag);
    if (sv_cyc.size() > ni) begin
      chk({tag, "_sample"}, 32'(sv_val[ni]), 32'(exp));
      ni++;
    end
  endtask

  task automatic wait_park(input int lim, input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < lim) begin
      tick(1);
      c++;
    end
    chk({tag, "_parked"}, 32'(busy), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, 32'(i2c_start), 0);
    chk({tag, "_addr"},  32'(i2c_addr), 32'(ADDR));
    chk({tag, "_data"},  32'(i2c_data), 0);
    chk({tag, "_two"},   32'(i2c_two_bytes), 0);
    chk({tag, "_rw"},    32'(i2c_rw), 0);
    chk({tag, "_sample"}, 32'(sample), 0);
    chk({tag, "_sv"},    32'(sample_valid), 0);
    chk({tag, "_init"},  32'(init_done), 0);
    chk({tag, "_err"},   32'(error), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  initial begin
    logic [15:0] v;
    int n0, c0;

    rst = 1'b1;
    enable = 1'b0;
    tick(3);
    @(negedge clk);
    check_reset("rst0");
    tick(1);
    rst = 1'b0;

    // Init write, first poll, with a random park time before enabling.
    tick($urandom_range(1, 6));
    enable  = 1'b1;
    rd_next = 16'h1A2B;
    next_start(K_INIT, "init", 50);
    chk("init_done_before_init", 32'(st_init[0]), 0);
    next_start(K_PTR, "ptr0", 80);
    chk("init_done_at_ptr", 32'(st_init[1]), 1);
    next_start(K_READ, "read0", 80);
    next_strobe(16'h1A2B, "strobe0", 80);
    next_start(K_PTR, "ptr1", P + 10);
    chk("poll_gap0", 32'(st_cyc[si-1] - sv_cyc[ni-1]), 32'(P));

    // Randomized polls.
    for (int r = 0; r < 3; r++) begin
      v = 16'($urandom);
      rd_next = v;
      next_start(K_READ, "read_r", 80);
      next_strobe(v, "strobe_r", 80);
      next_start(K_PTR, "ptr_r", P + 10);
      chk("poll_gap_r", 32'(st_cyc[si-1] - sv_cyc[ni-1]), 32'(P));
    end

    // Ack timeout on a pointer write.
    v = 16'($urandom);
    rd_next = v;
    next_start(K_READ, "read_t", 80);
    next_strobe(v, "strobe_t", 80);
    stuck = 1'b1;
    next_start(K_PTR, "ptr_stuck", P + 10);
    wait_q(2, 1, TO + 10, "timeout");
    chk("timeout_delay", 32'(er_cyc[0] - st_cyc[si-1]), 32'(TO));
    chk("timeout_no_strobe", 32'(sv_cyc.size()), 32'(ni));
    stuck = 1'b0;
    next_start(K_PTR, "ptr_retry", P + 20);
    chk("retry_gap", 32'(st_cyc[si-1] - er_cyc[0]), 32'(P + 1));

    // Enable dropped during the read: the read is still published, then park.
    v = 16'($urandom);
    rd_next = v;
    next_start(K_READ, "read_d", 80);
    enable = 1'b0;
    next_strobe(v, "strobe_d", 80);
    wait_park(P + 20, "drop");
    n0 = st_cyc.size();
    tick(10);
    chk("parked_no_start", 32'(st_cyc.size()), 32'(n0));
    chk("parked_init_kept", 32'(init_done), 1);
    enable = 1'b1;
    next_start(K_PTR, "reenable", 20);

    // Reset while the read is in S_DONE aborts it; init is re-run.
    rd_next = 16'($urandom);
    next_start(K_READ, "read_x", 80);
    tick(10);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_mid");
    tick(1);
    rst = 1'b0;
    n0 = sv_cyc.size();
    next_start(K_INIT, "reinit", 60);
    chk("reset_no_strobe", 32'(sv_cyc.size()), 32'(n0));
    enable = 1'b0;
    next_start(K_PTR, "ptr_x", 80);
    v = 16'($urandom);
    rd_next = v;
    next_start(K_READ, "read_y", 80);
    next_strobe(v, "strobe_y", 80);
    wait_park(P + 20, "drop2");

    // Ready held low for the first 5 cycles in S_ISSUE.
    hold_cnt = 6;
    tick(1);
    enable = 1'b1;
    c0 = cyc;
    next_start(K_PTR, "held", 30);
    chk("held_start_cycle", 32'(st_cyc[si-1]), 32'(c0 + 7));

    tick(5);
    chk("start_single_cycle", 32'(start_double), 0);
    chk("strobe_single_cycle", 32'(sv_double), 0);
    chk("error_count", 32'(er_cyc.size()), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
